dffr_pipe: RTL and testbench

//  Parametrised WIDTH x DEPTH register pipeline built from reset flops, with valid/ready flow control.

---
 rtl/dffr_pkg.sv | 19 +
 rtl/dffr_stage.sv | 65 ++++++
 rtl/dffr_pipe.sv | 87 ++++++++
 tb/tb_dffr_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dffr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : dffr_pkg                                                 |
// | Description : Shared constants and helpers for the dffr_pipe register  |
// |               pipeline (occupancy width, default reset data value).    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package dffr_pkg;

   // Default value loaded into every data register while RB is low.
   localparam int unsigned RSTVAL_DEFAULT = 0;

   // Bits needed to count 0..depth occupied stages.
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dffr_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dffr_stage                                               |
// | Description : One pipeline stage: WIDTH-bit data register, valid flop  |
// |               and local ready (stage empty or downstream moving).      |
// | Ports       : CK        clock, posedge                                 |
// |               RB        asynchronous reset, active low                 |
// |               flush_i   synchronous clear of the valid flop            |
// |               d_i/v_i   data/valid from upstream                       |
// |               rdy_nxt_i ready of the downstream stage (or consumer)    |
// |               q_o/v_o   registered data/valid                          |
// |               rdy_o     this stage can load this cycle                 |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module dffr_stage #(
   parameter int unsigned           WIDTH  = 8,
   parameter logic [WIDTH-1:0]      RSTVAL = '0
) (
   input  logic             CK,
   input  logic             RB,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             v_i,
   input  logic             rdy_nxt_i,
   output logic [WIDTH-1:0] q_o,
   output logic             v_o,
   output logic             rdy_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             v_q, v_d;

   // A stage may load when it is empty or its occupant moves on.
   assign rdy_o = !v_q | rdy_nxt_i;

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      if (flush_i) begin
         // Flush clears validity only; data is left untouched.
         v_d = 1'b0;
      end else if (rdy_o) begin
         v_d = v_i;
         // Bubbles do not overwrite data, so idle data lines stay quiet.
         if (v_i) begin
            data_d = d_i;
         end
      end
   end

   always_ff @(posedge CK or negedge RB) begin
      if (!RB) begin
         data_q <= RSTVAL;
         v_q    <= 1'b0;
      end else begin
         data_q <= data_d;
         v_q    <= v_d;
      end
   end

   assign q_o = data_q;
   assign v_o = v_q;

endmodule
`default_nettype wire

// File: rtl/dffr_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dffr_pipe                                                |
// | Description : WIDTH x DEPTH bubble-collapsing register pipeline with   |
// |               valid/ready flow control, async clear and sync flush.    |
// | Ports       : CK, RB (async active-low reset)                          |
// |               D/DV/DR   input data, valid, ready                       |
// |               Q/QV/QR   output data, valid, consumer ready             |
// |               FLUSH     synchronous clear of all valid flops           |
// |               OCC       number of occupied stages                      |
// |               QB        ~Q, only when DFFR_PIPE_QB_EN is defined       |
// | Config      : `define DFFR_PIPE_QB_EN adds the complementary output QB |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module dffr_pipe
   import dffr_pkg::*;
#(
   parameter int unsigned      WIDTH  = 8,
   parameter int unsigned      DEPTH  = 3,
   parameter logic [WIDTH-1:0] RSTVAL = WIDTH'(RSTVAL_DEFAULT)
) (
   input  logic                           CK,
   input  logic                           RB,
   input  logic [WIDTH-1:0]               D,
   input  logic                           DV,
   output logic                           DR,
   output logic [WIDTH-1:0]               Q,
   output logic                           QV,
   input  logic                           QR,
   input  logic                           FLUSH,
`ifdef DFFR_PIPE_QB_EN
   output logic [WIDTH-1:0]               QB,
`endif
   output logic [occ_width(DEPTH)-1:0]    OCC
);

   localparam int unsigned OW = occ_width(DEPTH);

   // Index i is the input side of stage i; index DEPTH is the pipe output.
   logic [WIDTH-1:0] stg_data [DEPTH+1];
   logic             stg_v    [DEPTH+1];
   logic             stg_rdy  [DEPTH+1];
   logic [OW-1:0]    occ_sum;

   assign stg_data[0]     = D;
   assign stg_v[0]        = DV;
   assign stg_rdy[DEPTH]  = QR;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
         dffr_stage #(
            .WIDTH  (WIDTH),
            .RSTVAL (RSTVAL)
         ) u_stage (
            .CK        (CK),
            .RB        (RB),
            .flush_i   (FLUSH),
            .d_i       (stg_data[i]),
            .v_i       (stg_v[i]),
            .rdy_nxt_i (stg_rdy[i+1]),
            .q_o       (stg_data[i+1]),
            .v_o       (stg_v[i+1]),
            .rdy_o     (stg_rdy[i])
         );
      end
   endgenerate

   // Ready ripples combinationally from QR; flush blocks new input.
   assign DR = stg_rdy[0] & !FLUSH;
   assign Q  = stg_data[DEPTH];
   assign QV = stg_v[DEPTH];

   always_comb begin
      occ_sum = '0;
      for (int i = 1; i <= DEPTH; i++) begin
         occ_sum = occ_sum + OW'(stg_v[i]);
      end
   end

   assign OCC = occ_sum;

`ifdef DFFR_PIPE_QB_EN
   assign QB = ~Q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dffr_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_dffr_pipe                                             |
// | Description : Self-checking bench for dffr_pipe (WIDTH=8, DEPTH=3).    |
// |               Reference model: FIFO of words, each tagged with the     |
// |               stage position it currently sits at.                     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_dffr_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;

   logic             CK = 1'b0;
   logic             RB;
   logic [WIDTH-1:0] D;
   logic             DV;
   logic             DR;
   logic [WIDTH-1:0] Q;
   logic             QV;
   logic             QR;
   logic             FLUSH;
   logic [1:0]       OCC;
`ifdef DFFR_PIPE_QB_EN
   logic [WIDTH-1:0] QB;
`endif

   dffr_pipe #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .RSTVAL (8'h00)
   ) dut (
      .CK    (CK),
      .RB    (RB),
      .D     (D),
      .DV    (DV),
      .DR    (DR),
      .Q     (Q),
      .QV    (QV),
      .QR    (QR),
      .FLUSH (FLUSH),
`ifdef DFFR_PIPE_QB_EN
      .QB    (QB),
`endif
      .OCC   (OCC)
   );

   always #5 CK = ~CK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] d;
      int         pos;
   } ent_t;

   ent_t       mq[$];
   int         np_g[$];
   logic [7:0] last_q = 8'h00;   // value held by the last-stage data register

   // New positions of all words for this edge; returns 1 when the oldest retires.
   function automatic bit calc_moves(input bit qr);
      bit ret = 1'b0;
      np_g.delete();
      for (int k = 0; k < mq.size(); k++) begin
         int p = mq[k].pos;
         int n = p;
         if (k == 0) begin
            if (p == DEPTH - 1) begin
               if (qr) ret = 1'b1;
            end else begin
               n = p + 1;
            end
         end else begin
            bit ahead_free = (k == 1 && ret) || (np_g[k-1] > p + 1);
            if (ahead_free && p < DEPTH - 1) n = p + 1;
         end
         np_g.push_back(n);
      end
      return ret;
   endfunction

   function automatic bit model_dr(input bit qr, input bit fl);
      bit ret;
      if (fl) return 1'b0;
      if (mq.size() == 0) return 1'b1;
      ret = calc_moves(qr);
      if (ret && mq.size() == 1) return 1'b1;
      return np_g[mq.size()-1] > 0;
   endfunction

   function automatic void model_edge(input bit dv, input logic [7:0] d, input bit qr, input bit fl);
      bit acc;
      bit ret;
      if (fl) begin
         mq.delete();
         return;
      end
      acc = dv && model_dr(qr, 1'b0);
      ret = calc_moves(qr);
      for (int k = 0; k < mq.size(); k++) begin
         if (mq[k].pos != DEPTH - 1 && np_g[k] == DEPTH - 1) last_q = mq[k].d;
         mq[k].pos = np_g[k];
      end
      if (ret) void'(mq.pop_front());
      if (acc) begin
         ent_t e;
         e.d   = d;
         e.pos = 0;
         mq.push_back(e);
         if (DEPTH == 1) last_q = d;
      end
   endfunction

   function automatic bit model_qv();
      return (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
   endfunction

   // ---------------- stimulus ----------------
   task automatic check_outputs(input string tag);
      chk({tag, "_QV"},  32'(QV),  32'(model_qv()));
      chk({tag, "_OCC"}, 32'(OCC), 32'(mq.size()));
      chk({tag, "_Q"},   32'(Q),   32'(last_q));
`ifdef DFFR_PIPE_QB_EN
      chk({tag, "_QB"},  32'(QB),  32'(~last_q));
`endif
   endtask

   // One cycle, entered and left just after a negedge.
   task automatic step(input bit dv, input logic [7:0] d, input bit qr, input bit fl);
      DV = dv; D = d; QR = qr; FLUSH = fl;
      #1;
      chk("DR", 32'(DR), 32'(model_dr(qr, fl)));
      @(posedge CK);
      model_edge(dv, d, qr, fl);
      #1;
      check_outputs("post");
      @(negedge CK);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      // 1: reset held with active input
      RB = 1'b0; DV = 1'b1; D = 8'hA5; QR = 1'b1; FLUSH = 1'b0;
      repeat (3) @(posedge CK);
      @(negedge CK);
      chk("rst_QV",  32'(QV),  32'h0);
      chk("rst_Q",   32'(Q),   32'h00);
      chk("rst_OCC", 32'(OCC), 32'h0);
      chk("rst_DR",  32'(DR),  32'h1);
`ifdef DFFR_PIPE_QB_EN
      chk("rst_QB",  32'(QB),  32'hFF);
`endif
      RB = 1'b1;

      // 2: streaming at full rate
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
      drain();

      // 3: stall and fill, then one release cycle
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b0);
      step(1'b1, 8'h44, 1'b0, 1'b0);
      chk("stall_OCC", 32'(OCC), 32'h3);
      chk("stall_Q",   32'(Q),   32'h11);
      chk("stall_DR",  32'(DR),  32'h0);
      step(1'b1, 8'h44, 1'b1, 1'b0);
      chk("release_Q",   32'(Q),   32'h22);
      chk("release_OCC", 32'(OCC), 32'h3);
      drain();

      // 4: bubble collapse behind a stalled word
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h5B, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("bubble_OCC", 32'(OCC), 32'h2);
      drain();

      // 5: flush with valid input present
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b0, 1'b1);
      chk("flush_QV",  32'(QV),  32'h0);
      chk("flush_OCC", 32'(OCC), 32'h0);
      drain();

      // 6: asynchronous reset between edges
      step(1'b1, 8'h81, 1'b0, 1'b0);
      step(1'b1, 8'h82, 1'b0, 1'b0);
      #2 RB = 1'b0;
      #1;
      mq.delete();
      last_q = 8'h00;
      chk("arst_QV",  32'(QV),  32'h0);
      chk("arst_OCC", 32'(OCC), 32'h0);
      chk("arst_Q",   32'(Q),   32'h00);
      @(negedge CK);
      @(negedge CK);
      RB = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
      drain();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 7), 8'($urandom()),
              ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
